// File: rtl/ctrl_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, ALU select
// indices, FSM states, instruction classes and the bundled control word.
package ctrl_pkg;

  localparam int unsigned OP_LD   = 0;
  localparam int unsigned OP_LDI  = 1;
  localparam int unsigned OP_ST   = 2;
  localparam int unsigned OP_ADD  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_ROR  = 7;
  localparam int unsigned OP_ROL  = 8;
  localparam int unsigned OP_SHR  = 9;
  localparam int unsigned OP_SHRA = 10;
  localparam int unsigned OP_SHL  = 11;
  localparam int unsigned OP_ADDI = 12;
  localparam int unsigned OP_ANDI = 13;
  localparam int unsigned OP_ORI  = 14;
  localparam int unsigned OP_DIV  = 15;
  localparam int unsigned OP_MUL  = 16;
  localparam int unsigned OP_NEG  = 17;
  localparam int unsigned OP_NOT  = 18;
  localparam int unsigned OP_BR   = 19;
  localparam int unsigned OP_JR   = 20;
  localparam int unsigned OP_JAL  = 21;
  localparam int unsigned OP_IN   = 22;
  localparam int unsigned OP_OUT  = 23;
  localparam int unsigned OP_MFHI = 24;
  localparam int unsigned OP_MFLO = 25;
  localparam int unsigned OP_NOP  = 26;
  localparam int unsigned OP_HALT = 27;

  // Bit positions inside the one-hot ALU select vector.
  localparam int ALU_N    = 13;
  localparam int ALU_AND  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUB  = 3;
  localparam int ALU_MUL  = 4;
  localparam int ALU_DIV  = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef logic [ALU_N-1:0] alu_vec_t;

  typedef enum logic [3:0] {
    RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_e;

  typedef enum logic [4:0] {
    CLS_RTYPE, CLS_IMM, CLS_UNARY, CLS_LD, CLS_LDI, CLS_ST, CLS_MULDIV,
    CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO,
    CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic     run;
    logic     illegal_op;
    logic     hi_out;
    logic     lo_out;
    logic     zhigh_out;
    logic     zlow_out;
    logic     pc_out;
    logic     mdr_out;
    logic     in_out;
    logic     c_out;
    logic     hi_in;
    logic     lo_in;
    logic     pc_in;
    logic     ir_in;
    logic     z_in;
    logic     y_in;
    logic     mar_in;
    logic     mdr_in;
    logic     con_in;
    logic     out_port_in;
    logic     gra;
    logic     grb;
    logic     grc;
    logic     r_in;
    logic     r_out;
    logic     ba_out;
    logic     pc_save;
    logic     read;
    logic     inc_pc;
    logic     write_mem;
    logic     con_reset;
    alu_vec_t alu;
  } ctrl_t;

  // Final execute step of each class; from here the FSM returns to T0.
  function automatic state_e last_step(instr_class_e cls);
    case (cls)
      CLS_RTYPE, CLS_IMM, CLS_LDI: return T5;
      CLS_UNARY, CLS_JAL:          return T4;
      CLS_LD, CLS_ST:              return T7;
      CLS_MULDIV, CLS_BR:          return T6;
      default:                     return T3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: maps IR[31:27] to an instruction class and the one-hot ALU
// operation the class uses. Define CTRL_MULDIV_EN to decode mul/div.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode,
  output instr_class_e     cls,
  output alu_vec_t         alu
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cls = CLS_ILLEGAL;
    alu = '0;
    case (opcode)
      OPC_W'(OP_LD):   begin cls = CLS_LD;    alu[ALU_ADD]  = 1'b1; end
      OPC_W'(OP_LDI):  begin cls = CLS_LDI;   alu[ALU_ADD]  = 1'b1; end
      OPC_W'(OP_ST):   begin cls = CLS_ST;    alu[ALU_ADD]  = 1'b1; end
      OPC_W'(OP_ADD):  begin cls = CLS_RTYPE; alu[ALU_ADD]  = 1'b1; end
      OPC_W'(OP_SUB):  begin cls = CLS_RTYPE; alu[ALU_SUB]  = 1'b1; end
      OPC_W'(OP_AND):  begin cls = CLS_RTYPE; alu[ALU_AND]  = 1'b1; end
      OPC_W'(OP_OR):   begin cls = CLS_RTYPE; alu[ALU_OR]   = 1'b1; end
      OPC_W'(OP_ROR):  begin cls = CLS_RTYPE; alu[ALU_ROR]  = 1'b1; end
      OPC_W'(OP_ROL):  begin cls = CLS_RTYPE; alu[ALU_ROL]  = 1'b1; end
      OPC_W'(OP_SHR):  begin cls = CLS_RTYPE; alu[ALU_SHR]  = 1'b1; end
      OPC_W'(OP_SHRA): begin cls = CLS_RTYPE; alu[ALU_SHRA] = 1'b1; end
      OPC_W'(OP_SHL):  begin cls = CLS_RTYPE; alu[ALU_SHL]  = 1'b1; end
      OPC_W'(OP_ADDI): begin cls = CLS_IMM;   alu[ALU_ADD]  = 1'b1; end
      OPC_W'(OP_ANDI): begin cls = CLS_IMM;   alu[ALU_AND]  = 1'b1; end
      OPC_W'(OP_ORI):  begin cls = CLS_IMM;   alu[ALU_OR]   = 1'b1; end
`ifdef CTRL_MULDIV_EN
      OPC_W'(OP_DIV):  begin cls = CLS_MULDIV; alu[ALU_DIV] = 1'b1; end
      OPC_W'(OP_MUL):  begin cls = CLS_MULDIV; alu[ALU_MUL] = 1'b1; end
`endif
      OPC_W'(OP_NEG):  begin cls = CLS_UNARY; alu[ALU_NEG]  = 1'b1; end
      OPC_W'(OP_NOT):  begin cls = CLS_UNARY; alu[ALU_NOT]  = 1'b1; end
      OPC_W'(OP_BR):   begin cls = CLS_BR;    alu[ALU_ADD]  = 1'b1; end
      OPC_W'(OP_JR):   cls = CLS_JR;
      OPC_W'(OP_JAL):  cls = CLS_JAL;
      OPC_W'(OP_IN):   cls = CLS_IN;
      OPC_W'(OP_OUT):  cls = CLS_OUT;
      OPC_W'(OP_MFHI): cls = CLS_MFHI;
      OPC_W'(OP_MFLO): cls = CLS_MFLO;
      OPC_W'(OP_NOP):  cls = CLS_NOP;
      OPC_W'(OP_HALT): cls = CLS_HALT;
      default:         cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath: fetch T0-T2,
// per-class execute T3-T7, HALT. CTRL_MULDIV_EN enables the mul/div sequences.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        stop,
  output logic        run,
  output logic        illegal_op,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INout,
  output logic        Cout,
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        CONin,
  output logic        OUT_Portin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCSave,
  output logic        Read,
  output logic        IncPC,
  output logic        write_mem,
  output logic        CON_RESET,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT
);

  state_e       state, next_state;
  instr_class_e cls;
  alu_vec_t     alu_sel;
  ctrl_t        c;

  // Operand fields are consumed by the datapath, not by the sequencer.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[31-OPC_W:0];

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode (IR[31 -: OPC_W]),
    .cls    (cls),
    .alu    (alu_sel)
  );

  // NOTE: state is sequential, so it uses non-blocking assignment; the
  // asynchronous reset drops every strobe without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RESET_S;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RESET_S: next_state = T0;
      T0:      next_state = T1;
      T1:      next_state = T2;
      T2:      next_state = T3;
      T3, T4, T5, T6, T7: begin
        if (state == T3 && cls == CLS_HALT)  next_state = HALT;
        else if (state == last_step(cls))    next_state = stop ? HALT : T0;
        else                                 next_state = state_e'(state + 4'd1);
      end
      HALT:    next_state = HALT;
      default: next_state = RESET_S;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      RESET_S: c.con_reset = 1'b1;
      T0: begin c.run = 1'b1; c.inc_pc = 1'b1; c.mar_in = 1'b1; c.pc_in = 1'b1; end
      T1: begin c.run = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      T2: begin c.run = 1'b1; c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      T3: begin
        c.run = 1'b1;
        case (cls)
          CLS_RTYPE, CLS_IMM: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          CLS_UNARY: begin c.grb = 1'b1; c.r_out = 1'b1; c.alu = alu_sel; c.z_in = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
`endif
          CLS_BR:      begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
          CLS_JR:      begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
          CLS_JAL:     begin c.pc_out = 1'b1; c.pc_save = 1'b1; c.r_in = 1'b1; end
          CLS_IN:      begin c.in_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CLS_OUT:     begin c.gra = 1'b1; c.r_out = 1'b1; c.out_port_in = 1'b1; end
          CLS_MFHI:    begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CLS_MFLO:    begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CLS_ILLEGAL: c.illegal_op = 1'b1;
          default: ;
        endcase
      end
      T4: begin
        c.run = 1'b1;
        case (cls)
          CLS_RTYPE: begin c.grc = 1'b1; c.r_out = 1'b1; c.alu = alu_sel; c.z_in = 1'b1; end
          CLS_IMM, CLS_LD, CLS_LDI, CLS_ST: begin
            c.c_out = 1'b1; c.alu = alu_sel; c.z_in = 1'b1;
          end
          CLS_UNARY: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin c.grb = 1'b1; c.r_out = 1'b1; c.alu = alu_sel; c.z_in = 1'b1; end
`endif
          CLS_BR:  begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          CLS_JAL: begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        c.run = 1'b1;
        case (cls)
          CLS_RTYPE, CLS_IMM, CLS_LDI: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CLS_LD, CLS_ST: begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
`endif
          CLS_BR: begin c.c_out = 1'b1; c.alu = alu_sel; c.z_in = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        c.run = 1'b1;
        case (cls)
          CLS_LD: begin c.read = 1'b1; c.mdr_in = 1'b1; end
          CLS_ST: begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
`ifdef CTRL_MULDIV_EN
          CLS_MULDIV: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
`endif
          // A branch not taken still spends this step, just with no strobes.
          CLS_BR: begin c.zlow_out = CON_FF; c.pc_in = CON_FF; end
          default: ;
        endcase
      end
      T7: begin
        c.run = 1'b1;
        case (cls)
          CLS_LD: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          CLS_ST: c.write_mem = 1'b1;
          default: ;
        endcase
      end
      HALT:    ;
      default: ;
    endcase
  end

  assign run        = c.run;
  assign illegal_op = c.illegal_op;
  assign HIout      = c.hi_out;
  assign LOout      = c.lo_out;
  assign Zhighout   = c.zhigh_out;
  assign Zlowout    = c.zlow_out;
  assign PCout      = c.pc_out;
  assign MDRout     = c.mdr_out;
  assign INout      = c.in_out;
  assign Cout       = c.c_out;
  assign HIin       = c.hi_in;
  assign LOin       = c.lo_in;
  assign PCin       = c.pc_in;
  assign IRin       = c.ir_in;
  assign Zin        = c.z_in;
  assign Yin        = c.y_in;
  assign MARin      = c.mar_in;
  assign MDRin      = c.mdr_in;
  assign CONin      = c.con_in;
  assign OUT_Portin = c.out_port_in;
  assign Gra        = c.gra;
  assign Grb        = c.grb;
  assign Grc        = c.grc;
  assign Rin        = c.r_in;
  assign Rout       = c.r_out;
  assign BAout      = c.ba_out;
  assign PCSave     = c.pc_save;
  assign Read       = c.read;
  assign IncPC      = c.inc_pc;
  assign write_mem  = c.write_mem;
  assign CON_RESET  = c.con_reset;
  assign AND        = c.alu[ALU_AND];
  assign OR         = c.alu[ALU_OR];
  assign ADD        = c.alu[ALU_ADD];
  assign SUB        = c.alu[ALU_SUB];
  assign MUL        = c.alu[ALU_MUL];
  assign DIV        = c.alu[ALU_DIV];
  assign SHR        = c.alu[ALU_SHR];
  assign SHRA       = c.alu[ALU_SHRA];
  assign SHL        = c.alu[ALU_SHL];
  assign ROR        = c.alu[ALU_ROR];
  assign ROL        = c.alu[ALU_ROL];
  assign NEG        = c.alu[ALU_NEG];
  assign NOT        = c.alu[ALU_NOT];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-instruction table model builds
// the expected strobe set for every cycle and a negedge process compares.
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, CON_FF, stop;
  logic [31:0] IR;
  logic run, illegal_op, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCSave, Read, IncPC, write_mem, CON_RESET;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .run(run), .illegal_op(illegal_op), .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
    .INout(INout), .Cout(Cout), .HIin(HIin), .LOin(LOin), .PCin(PCin),
    .IRin(IRin), .Zin(Zin), .Yin(Yin), .MARin(MARin), .MDRin(MDRin),
    .CONin(CONin), .OUT_Portin(OUT_Portin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .PCSave(PCSave), .Read(Read),
    .IncPC(IncPC), .write_mem(write_mem), .CON_RESET(CON_RESET),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT)
  );

  typedef logic [43:0] vec_t;

  vec_t dut_vec;
  assign dut_vec = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND,
                    CON_RESET, write_mem, IncPC, Read, PCSave, BAout, Rout, Rin,
                    Grc, Grb, Gra, OUT_Portin, CONin, MDRin, MARin, Yin, Zin, IRin,
                    PCin, LOin, HIin, Cout, INout, MDRout, PCout, Zlowout, Zhighout,
                    LOout, HIout, illegal_op, run};

  localparam vec_t R      = 44'd1 << 0;
  localparam vec_t ILL    = 44'd1 << 1;
  localparam vec_t HIOUT  = 44'd1 << 2;
  localparam vec_t LOOUT  = 44'd1 << 3;
  localparam vec_t ZHOUT  = 44'd1 << 4;
  localparam vec_t ZLOUT  = 44'd1 << 5;
  localparam vec_t PCOUT  = 44'd1 << 6;
  localparam vec_t MDROUT = 44'd1 << 7;
  localparam vec_t INOUT  = 44'd1 << 8;
  localparam vec_t COUT   = 44'd1 << 9;
  localparam vec_t HIIN   = 44'd1 << 10;
  localparam vec_t LOIN   = 44'd1 << 11;
  localparam vec_t PCIN   = 44'd1 << 12;
  localparam vec_t IRIN   = 44'd1 << 13;
  localparam vec_t ZIN    = 44'd1 << 14;
  localparam vec_t YIN    = 44'd1 << 15;
  localparam vec_t MARIN  = 44'd1 << 16;
  localparam vec_t MDRIN  = 44'd1 << 17;
  localparam vec_t CONIN  = 44'd1 << 18;
  localparam vec_t OUTPIN = 44'd1 << 19;
  localparam vec_t GRA    = 44'd1 << 20;
  localparam vec_t GRB    = 44'd1 << 21;
  localparam vec_t GRC    = 44'd1 << 22;
  localparam vec_t RIN    = 44'd1 << 23;
  localparam vec_t ROUT   = 44'd1 << 24;
  localparam vec_t BAOUT  = 44'd1 << 25;
  localparam vec_t PCSAVE = 44'd1 << 26;
  localparam vec_t READ   = 44'd1 << 27;
  localparam vec_t INCPC  = 44'd1 << 28;
  localparam vec_t WMEM   = 44'd1 << 29;
  localparam vec_t CONRST = 44'd1 << 30;
  localparam vec_t A_AND  = 44'd1 << 31;
  localparam vec_t A_OR   = 44'd1 << 32;
  localparam vec_t A_ADD  = 44'd1 << 33;
  localparam vec_t A_SUB  = 44'd1 << 34;
  localparam vec_t A_MUL  = 44'd1 << 35;
  localparam vec_t A_DIV  = 44'd1 << 36;
  localparam vec_t A_SHR  = 44'd1 << 37;
  localparam vec_t A_SHRA = 44'd1 << 38;
  localparam vec_t A_SHL  = 44'd1 << 39;
  localparam vec_t A_ROR  = 44'd1 << 40;
  localparam vec_t A_ROL  = 44'd1 << 41;
  localparam vec_t A_NEG  = 44'd1 << 42;
  localparam vec_t A_NOT  = 44'd1 << 43;

`ifdef CTRL_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  int   tests = 0;
  int   failed = 0;
  bit   chk_en = 1'b0;
  vec_t exp_vec;
  vec_t seq[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  function automatic vec_t alu_of(input int op);
    case (op)
      3, 12:  return A_ADD;
      4:      return A_SUB;
      5, 13:  return A_AND;
      6, 14:  return A_OR;
      7:      return A_ROR;
      8:      return A_ROL;
      9:      return A_SHR;
      10:     return A_SHRA;
      11:     return A_SHL;
      15:     return A_DIV;
      16:     return A_MUL;
      17:     return A_NEG;
      18:     return A_NOT;
      default: return '0;
    endcase
  endfunction

  // Expected strobe set for each cycle of one instruction, fetch included.
  function automatic void build_seq(input int op, input bit con);
    vec_t a;
    a = alu_of(op);
    seq.delete();
    seq.push_back(R | INCPC | MARIN | PCIN);
    seq.push_back(R | READ | MDRIN);
    seq.push_back(R | MDROUT | IRIN);
    if (op inside {[3:11]}) begin
      seq.push_back(R | GRB | ROUT | YIN);
      seq.push_back(R | GRC | ROUT | a | ZIN);
      seq.push_back(R | ZLOUT | GRA | RIN);
    end else if (op inside {[12:14]}) begin
      seq.push_back(R | GRB | ROUT | YIN);
      seq.push_back(R | COUT | a | ZIN);
      seq.push_back(R | ZLOUT | GRA | RIN);
    end else if (op == 17 || op == 18) begin
      seq.push_back(R | GRB | ROUT | a | ZIN);
      seq.push_back(R | ZLOUT | GRA | RIN);
    end else if (op <= 2) begin
      seq.push_back(R | GRB | BAOUT | YIN);
      seq.push_back(R | COUT | A_ADD | ZIN);
      if (op == 1) seq.push_back(R | ZLOUT | GRA | RIN);
      else begin
        seq.push_back(R | ZLOUT | MARIN);
        if (op == 0) begin
          seq.push_back(R | READ | MDRIN);
          seq.push_back(R | MDROUT | GRA | RIN);
        end else begin
          seq.push_back(R | GRA | ROUT | MDRIN);
          seq.push_back(R | WMEM);
        end
      end
    end else if ((op == 15 || op == 16) && MULDIV) begin
      seq.push_back(R | GRA | ROUT | YIN);
      seq.push_back(R | GRB | ROUT | a | ZIN);
      seq.push_back(R | ZLOUT | LOIN);
      seq.push_back(R | ZHOUT | HIIN);
    end else if (op == 19) begin
      seq.push_back(R | GRA | ROUT | CONIN);
      seq.push_back(R | PCOUT | YIN);
      seq.push_back(R | COUT | A_ADD | ZIN);
      seq.push_back(con ? (R | ZLOUT | PCIN) : R);
    end else if (op == 20) seq.push_back(R | GRA | ROUT | PCIN);
    else if (op == 21) begin
      seq.push_back(R | PCOUT | PCSAVE | RIN);
      seq.push_back(R | GRA | ROUT | PCIN);
    end
    else if (op == 22) seq.push_back(R | INOUT | GRA | RIN);
    else if (op == 23) seq.push_back(R | GRA | ROUT | OUTPIN);
    else if (op == 24) seq.push_back(R | HIOUT | GRA | RIN);
    else if (op == 25) seq.push_back(R | LOOUT | GRA | RIN);
    else if (op == 26 || op == 27) seq.push_back(R);
    else seq.push_back(R | ILL);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle", dut_vec, exp_vec);
      check("alu_onehot", 64'($countones(dut_vec[43:31]) <= 1), 64'd1);
    end
  end

  // Entered just after a rising edge; asserts reset mid-cycle.
  task automatic apply_reset();
    #2;
    reset = 1'b0;
    stop = 1'b0;
    exp_vec = CONRST;
    #1;
    check("async_reset", dut_vec, CONRST);
    @(posedge clk); #1;
    check("reset_held", dut_vec, CONRST);
    @(negedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input bit con, input bit stp, input int abort_at);
    int op;
    bit halts;
    op = int'(ir[31:27]);
    halts = (op == 27) || stp;
    build_seq(op, con);
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        IR = ir;
        CON_FF = con;
        stop = stp;
      end
      exp_vec = seq[i];
      if (i == abort_at) begin
        apply_reset();
        return;
      end
    end
    if (halts) begin
      repeat (12) begin
        @(posedge clk); #1;
        IR = $urandom;
        exp_vec = '0;
      end
      apply_reset();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [4:0] rop;
    reset = 1'b0;
    IR = '0;
    CON_FF = 1'b0;
    stop = 1'b0;
    exp_vec = CONRST;
    #1;
    check("reset_state", dut_vec, CONRST);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    build_seq(2, 1'b0);
    check("model_st_len", 64'(seq.size()), 64'd8);
    check("model_st_t7", seq[7], R | WMEM);
    build_seq(3, 1'b0);
    check("model_add_len", 64'(seq.size()), 64'd6);
    check("model_add_t4", seq[4], R | GRC | ROUT | A_ADD | ZIN);
    build_seq(19, 1'b0);
    check("model_br_len", 64'(seq.size()), 64'd7);
    check("model_br_nt_t6", seq[6], R);
    build_seq(19, 1'b1);
    check("model_br_t_t6", seq[6], R | ZLOUT | PCIN);
    build_seq(26, 1'b0);
    check("model_nop_len", 64'(seq.size()), 64'd4);

    run_instr(32'h10800067, 1'b0, 1'b0, -1);
    run_instr(32'h191A0000, 1'b0, 1'b0, -1);
    run_instr(32'h9A80000E, 1'b1, 1'b0, -1);
    run_instr(32'h9A80000E, 1'b0, 1'b0, -1);
    run_instr(32'h80000000, 1'b0, 1'b0, -1);
    run_instr(32'h7C800000, 1'b0, 1'b0, -1);
    run_instr(32'h00A00010, 1'b0, 1'b0, 5);
    run_instr(32'h191A0000, 1'b0, 1'b1, -1);
    run_instr(32'hD8000000, 1'b0, 1'b0, -1);

    for (int n = 0; n < 90; n++) begin
      rop = 5'($urandom_range(0, 31));
      run_instr({rop, 27'($urandom)}, 1'($urandom), $urandom_range(0, 15) == 0, -1);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
